// File: rtl/idt_gate_descriptor_fetch_pkg.sv
// Shared segmentation definitions: gate types, fault kinds and IDT error-code layout.
package idt_gate_descriptor_fetch_pkg;

  // System gate type nibbles that may appear in a descriptor's type field.
  typedef enum logic [3:0] {
    GATE_CALL16 = 4'h4,
    GATE_TASK   = 4'h5,
    GATE_INT16  = 4'h6,
    GATE_TRAP16 = 4'h7,
    GATE_CALL32 = 4'hC,
    GATE_INT32  = 4'hE,
    GATE_TRAP32 = 4'hF
  } gate_type_e;

  // Reason a fetch failed, as reported to the exception logic.
  typedef enum logic [1:0] {
    FAULT_GP  = 2'd0,
    FAULT_NP  = 2'd1,
    FAULT_BUS = 2'd2
  } fault_kind_e;

  localparam int ERR_EXT_BIT   = 0;
  localparam int ERR_IDT_BIT   = 1;
  localparam int DESC_TYPE_LSB = 40;
  localparam int DESC_P_BIT    = 47;

  // Only task, interrupt and trap gates may live in the IDT; call gates may not.
  function automatic logic isIdtGateType(input logic [3:0] typeField);
    case (typeField)
      GATE_TASK, GATE_INT16, GATE_TRAP16, GATE_INT32, GATE_TRAP32: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Selector-style error code naming the IDT entry: vector index, IDT flag and EXT flag.
  function automatic logic [15:0] idtErrorCode(input logic [7:0] vector, input logic ext);
    logic [15:0] code;
    code = 16'(vector) << 3;
    code[ERR_IDT_BIT] = 1'b1;
    code[ERR_EXT_BIT] = ext;
    return code;
  endfunction

endpackage

// File: rtl/idt_gate_descriptor_fetch_decode.sv
// Field extraction for a 64-bit segment/gate descriptor: type nibble and present bit.
module gate_segment_descriptor_decode
  import idt_gate_descriptor_fetch_pkg::*;
(
  input  logic [63:0] desc_i,
  output logic [3:0]  gateType_o,
  output logic        present_o
);

  logic unusedBits;

  assign gateType_o = desc_i[DESC_TYPE_LSB +: 4];
  assign present_o  = desc_i[DESC_P_BIT];
  assign unusedBits = ^{desc_i[63:48], desc_i[46:44], desc_i[39:0]};

endmodule

// File: rtl/idt_gate_descriptor_fetch.sv
// IDT gate descriptor fetch: limit check, two 32-bit reads, gate type/present check,
// then a one-cycle valid or fault report with an IDT-format error code.
module idt_gate_descriptor_fetch
  import idt_gate_descriptor_fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit CHECK_PRESENT  = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [7:0]  i_vector,
  input  logic        i_ext,
  input  logic [31:0] i_idtr_base,
  input  logic [15:0] i_idtr_limit,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy,
  output logic        o_valid,
  output logic [63:0] o_descriptor,
  output logic        o_fault,
  output logic [1:0]  o_fault_kind,
  output logic [15:0] o_error_code
);

  localparam int TimerW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerW-1:0] TimeoutLimit = TimerW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_LO,
    S_READ_HI,
    S_CHECK,
    S_REPORT
  } state_e;

  state_e            state_q;
  logic              busy_q;
  logic              memReq_q;
  logic [31:0]       memAddr_q;
  logic              valid_q;
  logic              fault_q;
  fault_kind_e       faultKind_q;
  logic [15:0]       errorCode_q;
  logic [63:0]       desc_q;
  logic [7:0]        vector_q;
  logic              ext_q;
  logic              pendFault_q;
  fault_kind_e       pendKind_q;
  logic [TimerW-1:0] timer_q;
  logic [TimerW-1:0] timer_d;

  logic [16:0] lastByte;
  logic        limitFault;
  logic [31:0] loAddr;
  logic        timedOut;
  logic [3:0]  gateType;
  logic        descPresent;

  // The last byte of the 8-byte entry must fall inside the inclusive limit.
  assign lastByte   = {6'd0, i_vector, 3'b111};
  assign limitFault = lastByte > {1'b0, i_idtr_limit};
  assign loAddr     = i_idtr_base + {21'd0, i_vector, 3'b000};
  assign timer_d    = timer_q + TimerW'(1);
  assign timedOut   = (TIMEOUT_CYCLES != 0) && (timer_q == TimeoutLimit);

  gate_segment_descriptor_decode uDecode (
    .desc_i     (desc_q),
    .gateType_o (gateType),
    .present_o  (descPresent)
  );

  // Fetch sequencer: owns every registered output and the per-read wait counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      memReq_q    <= 1'b0;
      memAddr_q   <= '0;
      valid_q     <= 1'b0;
      fault_q     <= 1'b0;
      faultKind_q <= FAULT_GP;
      errorCode_q <= '0;
      desc_q      <= '0;
      vector_q    <= '0;
      ext_q       <= 1'b0;
      pendFault_q <= 1'b0;
      pendKind_q  <= FAULT_GP;
      timer_q     <= '0;
    end else begin
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            vector_q <= i_vector;
            ext_q    <= i_ext;
            busy_q   <= 1'b1;
            timer_q  <= '0;
            if (limitFault) begin
              pendFault_q <= 1'b1;
              pendKind_q  <= FAULT_GP;
              state_q     <= S_REPORT;
            end else begin
              memReq_q  <= 1'b1;
              memAddr_q <= loAddr;
              state_q   <= S_READ_LO;
            end
          end
        end
        S_READ_LO: begin
          if (i_mem_ack) begin
            desc_q[31:0] <= i_mem_rdata;
            memAddr_q    <= memAddr_q + 32'd4;
            timer_q      <= '0;
            state_q      <= S_READ_HI;
          end else if (timedOut) begin
            memReq_q    <= 1'b0;
            pendFault_q <= 1'b1;
            pendKind_q  <= FAULT_BUS;
            state_q     <= S_REPORT;
          end else begin
            timer_q <= timer_d;
          end
        end
        S_READ_HI: begin
          if (i_mem_ack) begin
            desc_q[63:32] <= i_mem_rdata;
            memReq_q      <= 1'b0;
            timer_q       <= '0;
            state_q       <= S_CHECK;
          end else if (timedOut) begin
            memReq_q    <= 1'b0;
            pendFault_q <= 1'b1;
            pendKind_q  <= FAULT_BUS;
            state_q     <= S_REPORT;
          end else begin
            timer_q <= timer_d;
          end
        end
        S_CHECK: begin
          if (!isIdtGateType(gateType)) begin
            pendFault_q <= 1'b1;
            pendKind_q  <= FAULT_GP;
          end else if (CHECK_PRESENT && !descPresent) begin
            pendFault_q <= 1'b1;
            pendKind_q  <= FAULT_NP;
          end else begin
            pendFault_q <= 1'b0;
          end
          state_q <= S_REPORT;
        end
        S_REPORT: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
          if (pendFault_q) begin
            fault_q     <= 1'b1;
            faultKind_q <= pendKind_q;
            errorCode_q <= idtErrorCode(vector_q, ext_q);
          end else begin
            valid_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_busy       = busy_q;
  assign o_mem_req    = memReq_q;
  assign o_mem_addr   = memAddr_q;
  assign o_valid      = valid_q;
  assign o_fault      = fault_q;
  assign o_fault_kind = faultKind_q;
  assign o_error_code = errorCode_q;
  assign o_descriptor = desc_q;

endmodule

// File: tb/tb_idt_gate_descriptor_fetch.sv
// Bench for idt_gate_descriptor_fetch: two instances (present check on/off) share one
// memory responder; expectations come from a spec-level reference model via scoreboards.
module tb_idt_gate_descriptor_fetch;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  vector = '0;
   logic        ext = 1'b0;
   logic [31:0] base = '0;
   logic [15:0] limit = '0;
   logic        memAck = 1'b0;
   logic [31:0] memRdata = '0;

   logic        memReqA, busyA, validA, faultA;
   logic [31:0] memAddrA;
   logic [63:0] descA;
   logic [1:0]  kindA;
   logic [15:0] codeA;
   logic        memReqB, busyB, validB, faultB;
   logic [31:0] memAddrB;
   logic [63:0] descB;
   logic [1:0]  kindB;
   logic [15:0] codeB;

   typedef struct {
      bit          isFault;
      int          kind;
      logic [15:0] code;
      logic [63:0] desc;
      int          latency;
      int          startCycle;
   } expect_t;

   expect_t     expQA[$];
   expect_t     expQB[$];
   logic [31:0] addrQ[$];
   logic [31:0] mem [logic [31:0]];

   int dLo = 0;
   int dHi = 0;
   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int readIdx = 0;
   int waitCnt = 0;

   idt_gate_descriptor_fetch #(.TIMEOUT_CYCLES(4), .CHECK_PRESENT(1'b1)) dutA (
      .i_clk(clk), .i_reset(reset), .i_start(start), .i_vector(vector), .i_ext(ext),
      .i_idtr_base(base), .i_idtr_limit(limit), .o_mem_req(memReqA), .o_mem_addr(memAddrA),
      .i_mem_ack(memAck), .i_mem_rdata(memRdata), .o_busy(busyA), .o_valid(validA),
      .o_descriptor(descA), .o_fault(faultA), .o_fault_kind(kindA), .o_error_code(codeA)
   );

   idt_gate_descriptor_fetch #(.TIMEOUT_CYCLES(4), .CHECK_PRESENT(1'b0)) dutB (
      .i_clk(clk), .i_reset(reset), .i_start(start), .i_vector(vector), .i_ext(ext),
      .i_idtr_base(base), .i_idtr_limit(limit), .o_mem_req(memReqB), .o_mem_addr(memAddrB),
      .i_mem_ack(memAck), .i_mem_rdata(memRdata), .o_busy(busyB), .o_valid(validB),
      .o_descriptor(descB), .o_fault(faultB), .o_fault_kind(kindB), .o_error_code(codeB)
   );

   // Free-running clock and an edge counter used for latency checks.
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // One comparison: counts it and reports a failure with both values.
   task automatic checkValue(input string name, input int which, input logic [63:0] got,
                             input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s dut=%0d got=%h want=%h", name, which, got, want);
      end
   endtask

   // Reference model: the outcome of one fetch derived from the IDT rules directly.
   function automatic expect_t refModel(input logic [7:0] vec, input logic e,
                                        input logic [15:0] lim, input logic [31:0] lo,
                                        input logic [31:0] hi, input int dl, input int dh,
                                        input bit checkPresent);
      expect_t r;
      int      typ;
      bit      p;
      r.isFault    = 1'b1;
      r.kind       = 0;
      r.code       = 16'(int'(vec) * 8 + 2 + int'(e));
      r.desc       = '0;
      r.latency    = -1;
      r.startCycle = 0;
      typ = int'(hi[11:8]);
      p   = hi[15];
      if (int'(vec) * 8 + 7 > int'(lim)) begin
         r.kind    = 0;
         r.latency = 1;
      end else if (dl < 0 || dh < 0) begin
         r.kind = 2;
      end else begin
         r.latency = (dl + 1) + (dh + 1) + 2;
         if (!(typ inside {5, 6, 7, 14, 15})) r.kind = 0;
         else if (checkPresent && !p) r.kind = 1;
         else begin
            r.isFault = 1'b0;
            r.desc    = {hi, lo};
         end
      end
      return r;
   endfunction

   // Scoreboard side: whenever a DUT pulses, pop its expectation and compare.
   task automatic checkOutput(input int which, input logic v, input logic f,
                              input logic [1:0] k, input logic [15:0] c, input logic [63:0] d);
      expect_t e;
      int      qSize;
      if (!(v || f)) return;
      checkValue("singlePulse", which, 64'(v && f), 64'd0);
      qSize = (which == 0) ? expQA.size() : expQB.size();
      if (qSize == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL unexpectedPulse dut=%0d got valid=%0b fault=%0b want none", which, v, f);
         return;
      end
      if (which == 0) e = expQA.pop_front();
      else e = expQB.pop_front();
      checkValue("pulseIsFault", which, 64'(f), 64'(e.isFault));
      if (e.isFault) begin
         checkValue("faultKind", which, 64'(k), 64'(e.kind));
         checkValue("errorCode", which, 64'(c), 64'(e.code));
      end else begin
         checkValue("descriptor", which, d, e.desc);
      end
      if (e.latency >= 0) checkValue("latency", which, 64'(cycle - e.startCycle), 64'(e.latency));
   endtask

   // Monitor for both instances, sampled away from the rising edge.
   always @(negedge clk) begin
      checkOutput(0, validA, faultA, kindA, codeA, descA);
      checkOutput(1, validB, faultB, kindB, codeB, descB);
   end

   // Memory responder: acks after a programmed number of wait cycles, never if negative.
   always @(negedge clk) begin
      int d;
      if (reset || !memReqA) begin
         memAck  = 1'b0;
         readIdx = 0;
         waitCnt = 0;
      end else begin
         d = (readIdx == 0) ? dLo : dHi;
         if (d >= 0 && waitCnt >= d) begin
            memAck   = 1'b1;
            memRdata = mem.exists(memAddrA) ? mem[memAddrA] : 32'h0;
            if (addrQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpectedRead got addr=%h want no request", memAddrA);
            end else begin
               checkValue("readAddr", 0, 64'(memAddrA), 64'(addrQ[0]));
               checkValue("readAddr", 1, 64'(memAddrB), 64'(addrQ[0]));
               void'(addrQ.pop_front());
            end
            readIdx++;
            waitCnt = 0;
         end else begin
            memAck = 1'b0;
            waitCnt++;
         end
      end
   end

   // Issue one fetch, queue the expected results and wait (bounded) for both reports.
   task automatic applyStimulus(input logic [7:0] vec, input logic e, input logic [31:0] b,
                                input logic [15:0] lim, input logic [31:0] lo,
                                input logic [31:0] hi, input int dl, input int dh,
                                input bit poke);
      expect_t     eA, eB;
      logic [31:0] loA, hiA;
      int          n;
      loA = b + 32'(vec) * 32'd8;
      hiA = loA + 32'd4;
      mem[loA] = lo;
      mem[hiA] = hi;
      eA = refModel(vec, e, lim, lo, hi, dl, dh, 1'b1);
      eB = refModel(vec, e, lim, lo, hi, dl, dh, 1'b0);
      @(negedge clk);
      addrQ.delete();
      if (int'(vec) * 8 + 7 <= int'(lim)) begin
         addrQ.push_back(loA);
         addrQ.push_back(hiA);
      end
      dLo = dl;
      dHi = dh;
      vector = vec;
      ext = e;
      base = b;
      limit = lim;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      eA.startCycle = cycle;
      eB.startCycle = cycle;
      expQA.push_back(eA);
      expQB.push_back(eB);
      if (poke) begin
         @(negedge clk);
         checkValue("busyDuringFetch", 0, 64'(busyA), 64'd1);
         vector = ~vec;
         start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      n = 0;
      while ((expQA.size() != 0 || expQB.size() != 0) && n < 80) begin
         @(negedge clk);
         n++;
      end
      if (expQA.size() != 0 || expQB.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL completion got pending=%0d want 0 within 80 cycles",
                  expQA.size() + expQB.size());
         expQA.delete();
         expQB.delete();
      end
   endtask

   // Abandon a fetch with reset while the high word is outstanding.
   task automatic applyResetMidFetch();
      logic [31:0] loA;
      loA = 32'h0000_2000 + 32'd24;
      mem[loA] = 32'h1111_2222;
      mem[loA + 32'd4] = 32'h0000_8E00;
      @(negedge clk);
      addrQ.delete();
      addrQ.push_back(loA);
      dLo = 0;
      dHi = -1;
      vector = 8'd3;
      ext = 1'b0;
      base = 32'h0000_2000;
      limit = 16'hFFFF;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkValue("reqInReadHi", 0, 64'(memReqA), 64'd1);
      checkValue("addrInReadHi", 0, 64'(memAddrA), 64'(loA + 32'd4));
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkValue("reqAfterReset", 0, 64'(memReqA), 64'd0);
      checkValue("reqAfterReset", 1, 64'(memReqB), 64'd0);
      checkValue("busyAfterReset", 0, 64'(busyA), 64'd0);
      checkValue("busyAfterReset", 1, 64'(busyB), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   // Hard stop in case something wedges the bench itself.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got no finish want finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed cases first, then randomized fetches, then the summary.
   initial begin
      repeat (3) @(negedge clk);
      checkValue("resetDesc", 0, descA, 64'd0);
      checkValue("resetDesc", 1, descB, 64'd0);
      checkValue("resetCtrl", 0, 64'({busyA, memReqA, validA, faultA, kindA, codeA, memAddrA}), 64'd0);
      checkValue("resetCtrl", 1, 64'({busyB, memReqB, validB, faultB, kindB, codeB, memAddrB}), 64'd0);
      reset = 1'b0;

      applyStimulus(8'h0E, 1'b0, 32'h0000_1000, 16'h07FF, 32'h0008_1234, 32'h00C0_8E00, 0, 0, 1'b0);
      applyStimulus(8'h0E, 1'b1, 32'h0000_1000, 16'h006F, 32'h0008_1234, 32'h00C0_8E00, 0, 0, 1'b0);
      applyStimulus(8'h21, 1'b0, 32'h0000_1000, 16'h07FF, 32'h0010_0000, 32'h0000_0C00, 0, 0, 1'b0);
      applyStimulus(8'h30, 1'b0, 32'h0000_1000, 16'h07FF, 32'h0010_5555, 32'h0000_0E00, 0, 0, 1'b0);
      applyStimulus(8'h31, 1'b1, 32'h0000_1000, 16'h07FF, 32'h0010_6666, 32'h0000_8500, 1, 0, 1'b0);
      applyStimulus(8'h32, 1'b0, 32'h0000_1000, 16'h07FF, 32'h0010_7777, 32'h0000_8400, 0, 1, 1'b0);
      applyStimulus(8'h40, 1'b0, 32'h0000_3000, 16'hFFFF, 32'hAAAA_0000, 32'h0000_8F00, -1, 0, 1'b0);
      applyStimulus(8'h40, 1'b0, 32'h0000_3000, 16'hFFFF, 32'hAAAA_0001, 32'h0000_8F00, 3, 3, 1'b0);
      applyStimulus(8'h41, 1'b1, 32'h0000_3000, 16'hFFFF, 32'hAAAA_0002, 32'h0000_8F00, 0, -1, 1'b0);
      applyStimulus(8'h00, 1'b0, 32'hFFFF_FFF8, 16'hFFFF, 32'h1234_5678, 32'h0000_8E00, 0, 0, 1'b0);
      applyStimulus(8'h00, 1'b0, 32'hFFFF_FFFC, 16'hFFFF, 32'h8765_4321, 32'h0000_EF00, 0, 0, 1'b0);
      applyStimulus(8'h80, 1'b0, 32'h0000_4000, 16'hFFFF, 32'h0BAD_F00D, 32'h0000_8600, 2, 1, 1'b1);
      applyStimulus(8'h01, 1'b1, 32'h0000_0000, 16'h000F, 32'h0000_0001, 32'h0000_8E00, 0, 0, 1'b0);
      applyStimulus(8'h02, 1'b0, 32'h0000_0000, 16'h0016, 32'h0000_0002, 32'h0000_8E00, 0, 0, 1'b0);
      applyResetMidFetch();

      for (int i = 0; i < 40; i++) begin
         logic [7:0]  v;
         logic [15:0] lim;
         logic [31:0] b, lo, hi;
         int          dl, dh;
         v = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 1) == 1) lim = 16'($urandom);
         else lim = 16'(int'(v) * 8 + int'($urandom_range(0, 14)) - 7);
         if ($urandom_range(0, 3) == 0) b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         else b = $urandom;
         lo = $urandom;
         hi = $urandom;
         hi[11:8] = 4'($urandom_range(0, 15));
         hi[15] = 1'($urandom_range(0, 1));
         dl = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 2));
         dh = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 2));
         applyStimulus(v, 1'($urandom_range(0, 1)), b, lim, lo, hi, dl, dh, 1'b0);
      end

      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/idt_gate_descriptor_fetch.md
Name: idt_gate_descriptor_fetch

Overview:
Fetches the 64-bit interrupt descriptor table (IDT) gate descriptor for an interrupt or exception vector. It sits directly upstream of the gate descriptor decoder in the segmentation unit. The block does the IDTR limit check, reads the descriptor as two 32-bit words over the memory request/ack port, and checks gate type and present bit. It then hands the assembled descriptor downstream, or raises a fault with an 80386-format error code.

Parameters:
TIMEOUT_CYCLES, 255, cycles one read may wait for i_mem_ack before the fetch aborts with a bus fault; 0 disables the timeout.
CHECK_PRESENT, 1, when 1 a descriptor with P=0 raises #NP; when 0 the P bit is not checked.

Ports:
i_clk  in  1  clock; all state changes on the rising edge.
i_reset  in  1  synchronous reset, active high.
i_start  in  1  request a fetch; accepted only while o_busy=0.
i_vector  in  8  interrupt/exception vector number.
i_ext  in  1  external-event flag; copied to bit 0 of the error code.
i_idtr_base  in  32  IDTR base, linear address.
i_idtr_limit  in  16  IDTR limit, in bytes, inclusive.
o_mem_req  out  1  read request; held until acknowledged.
o_mem_addr  out  32  read address; stable while o_mem_req=1.
i_mem_ack  in  1  read accepted; i_mem_rdata is valid in the same cycle.
i_mem_rdata  in  32  read data.
o_busy  out  1  a fetch is in progress.
o_valid  out  1  one-cycle pulse: o_descriptor holds a good gate descriptor.
o_descriptor  out  64  assembled descriptor {hi_word, lo_word}; held until the next accepted start.
o_fault  out  1  one-cycle pulse: the fetch failed.
o_fault_kind  out  2  0=#GP (limit or type), 1=#NP, 2=bus timeout.
o_error_code  out  16  {i_vector, 1'b0, 1'b1 (IDT), i_ext} = vector*8 + 2 + ext.

Behaviour:
- Reset: state IDLE; o_busy, o_mem_req, o_valid and o_fault are 0; o_descriptor, o_mem_addr, o_fault_kind and o_error_code are 0; timeout counter is 0.
- Reset mid-fetch: the fetch is abandoned immediately; no o_valid or o_fault is produced.
- States: IDLE, READ_LO, READ_HI, CHECK, REPORT.
- IDLE: when i_start=1 and o_busy=0, latch vector, ext, base and limit.
  - Limit check uses 17-bit arithmetic: fault if {vector,3'b111} > limit.
  - On limit fault go to REPORT with kind 0. Otherwise go to READ_LO.
  - i_start while o_busy=1 is ignored; it is not queued.
- Addresses: lo word at base + vector*8, hi word at lo address + 4, modulo 2^32 (the address wraps).
- READ_LO and READ_HI:
  - o_mem_req=1 and o_busy=1 throughout.
  - On i_mem_ack, capture i_mem_rdata into the lo or hi word and move on (READ_LO -> READ_HI -> CHECK).
  - The timeout counter clears on entry to each read and increments each cycle without ack.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES, go to REPORT with kind 2.
  - An ack received in the same cycle the counter reaches TIMEOUT_CYCLES takes priority over the timeout.
- CHECK (one cycle):
  - Type = descriptor bits [43:40].
  - Legal types: 5 (task gate), 6, 7, 0xE, 0xF. Any other type, including call gates 4 and 0xC, is #GP (kind 0).
  - If the type is legal, CHECK_PRESENT=1 and P (bit 47) = 0, the result is #NP (kind 1).
  - Go to REPORT.
- REPORT (one cycle):
  - Pulse exactly one of o_valid or o_fault.
  - o_error_code is valid whenever o_fault=1.
  - o_busy=1 in REPORT; return to IDLE.
  - A new i_start is accepted in the following IDLE cycle.
- Latency with zero-wait ack: start accepted at edge 0; reads complete at edges 1 and 2; CHECK at edge 3; o_valid/o_fault high during the cycle after edge 4.
- A limit fault skips the reads: o_fault is high during the cycle after edge 1.
- o_descriptor updates when each word is captured; consumers sample it only on o_valid.

Decomposition:
- Shared segmentation package holds:
  - the gate-type enum (values 4,5,6,7,C,E,F);
  - the fault-kind enum (GP=0, NP=1, BUS=2);
  - the IDT error-code bit positions (EXT=0, IDT=1).
- One sub-module: instantiate gate_segment_descriptor_decode on the assembled descriptor for the type and P fields.
- The FSM and timeout counter live in this module.

Test Plan:
- Base 0x0000_1000, limit 0x07FF, vector 0x0E, immediate acks with lo 0x0008_1234, hi 0x00C0_8E00 -> addresses 0x1070 then 0x1074; o_valid after 4 edges; o_descriptor 0x00C0_8E00_0008_1234.
- Limit 0x006F, vector 0x0E (0x77 > 0x6F), ext=1 -> no o_mem_req; o_fault kind 0; o_error_code 0x0073.
- hi word 0x0000_0C00 (P=0, type 0xC call gate), vector 0x21 -> #GP kind 0 (type checked first); code 0x010A.
- hi word 0x0000_0E00 (P=0, type 0xE) -> #NP kind 1; repeat with CHECK_PRESENT=0 -> o_valid.
- TIMEOUT_CYCLES=4, no ack on the lo read -> o_fault kind 2 after the timeout; second run with ack on the 4th wait cycle -> fetch continues with no fault.
- Base 0xFFFF_FFF8, vector 0 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC; base 0xFFFF_FFFC -> hi address wraps to 0x0000_0000; i_reset in READ_HI -> o_mem_req=0 next cycle, no pulse; i_start while busy is ignored.
